// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter between several byte-stream sources. A source
//   raises its lock line for a whole message and, once granted, owns the
//   transmitter exclusively. Locks are granted round-robin. Each source sees a
//   private busy flag that rises on the cycle after its strobe is accepted and
//   stays high until the UART has finished the byte. This closes the gap
//   between a strobe and the UART raising tx_busy.
//
// Ports
//   clock_i        system clock, rising edge
//   reset_i        synchronous, active-high
//   req_lock_i     per-source lock, held high for a whole message
//   req_valid_i    per-source 1-cycle strobe: send req_byte_i[8*i +: 8]
//   req_byte_i     packed bytes, source i at [8*i +: 8]
//   req_tx_busy_o  per-source busy; low only for the owner when it may strobe
//   grant_o        one-hot owner, all-zero when idle
//   tx_start_o     1-cycle strobe to the UART
//   tx_byte_o      byte to the UART, stable until the next accepted byte
//   tx_busy_i      UART busy
//   timeout_err_o  sticky: the UART failed to acknowledge a tx_start in time
//   drop_count_o   saturating count of cycles with a rejected strobe
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_lock_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_byte_i,
  output logic [NUM_REQ-1:0]   req_tx_busy_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 tx_start_o,
  output logic [7:0]           tx_byte_o,
  input  logic                 tx_busy_i,
  output logic                 timeout_err_o,
  output logic [7:0]           drop_count_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    OWNED,
    WAIT_BUSY,
    DRAIN
  } state_e;

  state_e               state_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   req_tx_busy_q;
  logic                 tx_start_q;
  logic [7:0]           tx_byte_q;
  logic [7:0]           ack_cnt_q;
  logic                 timeout_err_q;
  logic [7:0]           drop_count_q;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     cand;
  int                   idx;
  logic [IDX_W-1:0]     rr_next;
  logic                 owner_lock;
  logic                 owner_valid;
  logic                 accept;
  logic                 reject;

  // Round-robin pick: scan offsets from the highest down so the first set
  // lock at the lowest offset from rr_ptr_q is the one that sticks.
  // NOTE: every variable gets a default before the loop; a path that leaves
  // one unassigned would make synthesis infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    idx        = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (req_lock_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign rr_next     = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign owner_lock  = req_lock_i[owner_q];
  assign owner_valid = req_valid_i[owner_q];

  // Only the owner's busy bit can ever be low, and only in OWNED, so a strobe
  // is accepted exactly when it hits a low busy bit and rejected otherwise.
  assign accept = |(req_valid_i & ~req_tx_busy_q);
  assign reject = |(req_valid_i & req_tx_busy_q);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge values regardless of statement order.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      req_tx_busy_q <= '1;
      tx_start_q    <= 1'b0;
      tx_byte_q     <= 8'h00;
      ack_cnt_q     <= 8'h00;
      timeout_err_q <= 1'b0;
      drop_count_q  <= 8'h00;
    end else begin
      tx_start_q    <= 1'b0;
      req_tx_busy_q <= '1;

      if (reject && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 8'd1;

      unique case (state_q)
        IDLE: begin
          // Never hand out a grant while a byte (possibly from before a
          // reset) is still leaving the UART.
          if (pick_found && !tx_busy_i) begin
            owner_q                 <= pick_idx;
            grant_q                 <= NUM_REQ'(1) << pick_idx;
            req_tx_busy_q[pick_idx] <= 1'b0;
            state_q                 <= OWNED;
          end
        end

        OWNED: begin
          if (accept) begin
            tx_byte_q  <= req_byte_i[{owner_q, 3'b000} +: 8];
            tx_start_q <= 1'b1;
            ack_cnt_q  <= 8'(ACK_TIMEOUT);
            state_q    <= WAIT_BUSY;
          end else if (!owner_lock && !owner_valid) begin
            grant_q  <= '0;
            rr_ptr_q <= rr_next;
            state_q  <= IDLE;
          end else if (!tx_busy_i) begin
            req_tx_busy_q[owner_q] <= 1'b0;
          end
        end

        WAIT_BUSY: begin
          if (tx_busy_i) begin
            state_q <= DRAIN;
          end else if (ack_cnt_q <= 8'd1) begin
            // UART never acknowledged: abandon the byte and flag it.
            timeout_err_q <= 1'b1;
            if (owner_lock) begin
              req_tx_busy_q[owner_q] <= 1'b0;
              state_q                <= OWNED;
            end else begin
              grant_q  <= '0;
              rr_ptr_q <= rr_next;
              state_q  <= IDLE;
            end
          end else begin
            ack_cnt_q <= ack_cnt_q - 8'd1;
          end
        end

        DRAIN: begin
          if (!tx_busy_i) begin
            if (owner_lock) begin
              req_tx_busy_q[owner_q] <= 1'b0;
              state_q                <= OWNED;
            end else begin
              grant_q  <= '0;
              rr_ptr_q <= rr_next;
              state_q  <= IDLE;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_tx_busy_o = req_tx_busy_q;
  assign grant_o       = grant_q;
  assign tx_start_o    = tx_start_q;
  assign tx_byte_o     = tx_byte_q;
  assign timeout_err_o = timeout_err_q;
  assign drop_count_o  = drop_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter with NUM_REQ=3, ACK_TIMEOUT=15.
//   A small UART model raises tx_busy for 10 cycles per tx_start (or never,
//   when disabled) and logs every transmitted byte and every new grant.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   lock;
  logic [N-1:0]   valid;
  logic [8*N-1:0] bytes;
  logic [N-1:0]   rtb;
  logic [N-1:0]   grant;
  logic           tx_start;
  logic [7:0]     tx_byte;
  logic           tx_busy;
  logic           terr;
  logic [7:0]     dcnt;

  int total = 0;
  int bad   = 0;

  int         busy_cnt = 0;
  bit         uart_en  = 1'b1;
  logic [7:0] tx_log[$];
  logic [N-1:0] grant_log[$];
  logic [N-1:0] prev_grant = '0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(TO)) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .req_lock_i    (lock),
    .req_valid_i   (valid),
    .req_byte_i    (bytes),
    .req_tx_busy_o (rtb),
    .grant_o       (grant),
    .tx_start_o    (tx_start),
    .tx_byte_o     (tx_byte),
    .tx_busy_i     (tx_busy),
    .timeout_err_o (terr),
    .drop_count_o  (dcnt)
  );

  // UART model and logger, updated 2 time units after each rising edge so it
  // never races with the stimulus tasks acting on the falling edge.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (busy_cnt > 0) busy_cnt--;
      if (tx_start && uart_en) busy_cnt = 10;
      tx_busy = (busy_cnt > 0);
      if (tx_start) tx_log.push_back(tx_byte);
      if (grant != prev_grant && grant != '0) grant_log.push_back(grant);
      prev_grant = grant;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    for (int i = 0; i < 100 && busy_cnt != 0; i++) @(negedge clk);
    rst   = 1'b1;
    lock  = '0;
    valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int idx);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rtb[idx] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_ready[%0d]: req_tx_busy stayed 1 for 200 cycles", idx);
    end
  endtask

  task automatic send_byte(input int idx, input logic [7:0] b);
    valid[idx]       = 1'b1;
    bytes[8*idx +: 8] = b;
    @(negedge clk);
    valid[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    lock  = '0;
    valid = '0;
    bytes = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({grant, tx_start, tx_byte, dcnt, terr} !== {3'b000, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got grant=%b start=%b byte=%h drop=%h terr=%b, want all zero",
               grant, tx_start, tx_byte, dcnt, terr);
    end
    total++;
    if (rtb !== 3'b111) begin
      bad++;
      $display("FAIL reset_busy: got %b want 111", rtb);
    end
    rst = 1'b0;
  endtask

  // Req0 sends "ACSP\0" paced by its busy flag.
  task automatic test_basic();
    logic [7:0] msg [5];
    int base;
    msg = '{8'h41, 8'h43, 8'h53, 8'h50, 8'h00};
    apply_reset();
    base = tx_log.size();
    lock[0] = 1'b1;
    @(negedge clk);
    total++;
    if (grant !== 3'b001 || rtb !== 3'b110) begin
      bad++;
      $display("FAIL basic_grant: got grant=%b busy=%b want 001/110", grant, rtb);
    end
    for (int k = 0; k < 5; k++) begin
      wait_ready(0);
      send_byte(0, msg[k]);
      if (k == 0) begin
        total++;
        if (tx_start !== 1'b1 || tx_byte !== 8'h41 || rtb[0] !== 1'b1) begin
          bad++;
          $display("FAIL basic_latency: got start=%b byte=%h busy0=%b want 1/41/1",
                   tx_start, tx_byte, rtb[0]);
        end
      end
    end
    wait_ready(0);
    lock[0] = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== 3'b000) begin
      bad++;
      $display("FAIL basic_release: got grant=%b want 000", grant);
    end
    total++;
    if (tx_log.size() - base != 5) begin
      bad++;
      $display("FAIL basic_count: got %0d tx_start want 5", tx_log.size() - base);
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (tx_log[base+k] !== msg[k]) begin
          bad++;
          $display("FAIL basic_byte[%0d]: got %h want %h", k, tx_log[base+k], msg[k]);
        end
      end
    end
    total++;
    if (dcnt !== 8'h00) begin
      bad++;
      $display("FAIL basic_drop: got %0d want 0", dcnt);
    end
  endtask

  // Three simultaneous locks, each sends one byte and drops lock with it.
  task automatic test_round_robin();
    int base;
    int owner;
    bit ok;
    apply_reset();
    base = grant_log.size();
    lock = 3'b111;
    for (int k = 0; k < 3; k++) begin
      owner = -1;
      for (int c = 0; c < 200 && owner < 0; c++) begin
        for (int i = 0; i < N; i++) if (rtb[i] === 1'b0) owner = i;
        if (owner < 0) @(negedge clk);
      end
      total++;
      if (owner != k) begin
        bad++;
        $display("FAIL rr_owner[%0d]: got %0d want %0d", k, owner, k);
      end
      if (owner >= 0) begin
        valid[owner] = 1'b1;
        lock[owner]  = 1'b0;
        bytes[8*owner +: 8] = 8'h60 + 8'(k);
        @(negedge clk);
        valid = '0;
        total++;
        if (tx_start !== 1'b1 || tx_byte !== 8'h60 + 8'(k)) begin
          bad++;
          $display("FAIL rr_byte[%0d]: got start=%b byte=%h want 1/%h",
                   k, tx_start, tx_byte, 8'h60 + 8'(k));
        end
      end
    end
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (grant === 3'b000 && busy_cnt == 0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || grant_log.size() - base != 3) begin
      bad++;
      $display("FAIL rr_order_len: got %0d grants idle=%b want 3", grant_log.size() - base, ok);
    end else begin
      total++;
      if (grant_log[base] !== 3'b001 || grant_log[base+1] !== 3'b010 || grant_log[base+2] !== 3'b100) begin
        bad++;
        $display("FAIL rr_order: got %b %b %b want 001 010 100",
                 grant_log[base], grant_log[base+1], grant_log[base+2]);
      end
    end
    lock = 3'b101;
    @(negedge clk);
    total++;
    if (grant !== 3'b001) begin
      bad++;
      $display("FAIL rr_wrap: got grant=%b want 001", grant);
    end
    lock = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int base;
    apply_reset();
    lock[1] = 1'b1;
    wait_ready(1);
    base = tx_log.size();
    valid[1] = 1'b1;
    bytes[15:8] = 8'h5A;
    @(negedge clk);
    bytes[15:8] = 8'h5B;
    @(negedge clk);
    valid[1] = 1'b0;
    total++;
    if (dcnt !== 8'd1) begin
      bad++;
      $display("FAIL b2b_drop: got %0d want 1", dcnt);
    end
    wait_ready(1);
    total++;
    if (tx_log.size() - base != 1 || tx_log[base] !== 8'h5A) begin
      bad++;
      $display("FAIL b2b_single: got %0d starts first=%h want 1 of 5A",
               tx_log.size() - base, tx_log[base]);
    end
    valid[2] = 1'b1;
    bytes[23:16] = 8'h99;
    @(negedge clk);
    valid[2] = 1'b0;
    total++;
    if (dcnt !== 8'd2 || grant !== 3'b010 || tx_start !== 1'b0) begin
      bad++;
      $display("FAIL nonowner_drop: got drop=%0d grant=%b start=%b want 2/010/0",
               dcnt, grant, tx_start);
    end
    lock = '0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    apply_reset();
    uart_en = 1'b0;
    lock[0] = 1'b1;
    wait_ready(0);
    send_byte(0, 8'h77);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      if (k == TO - 1) begin
        total++;
        if (terr !== 1'b0 || rtb[0] !== 1'b1) begin
          bad++;
          $display("FAIL timeout_early: got terr=%b busy0=%b at %0d want 0/1", terr, rtb[0], k);
        end
      end
    end
    total++;
    if (terr !== 1'b1 || rtb[0] !== 1'b0 || grant !== 3'b001) begin
      bad++;
      $display("FAIL timeout_fire: got terr=%b busy0=%b grant=%b want 1/0/001", terr, rtb[0], grant);
    end
    uart_en = 1'b1;
    lock = '0;
    repeat (2) @(negedge clk);
    total++;
    if (terr !== 1'b1 || grant !== 3'b000) begin
      bad++;
      $display("FAIL timeout_sticky: got terr=%b grant=%b want 1/000", terr, grant);
    end
  endtask

  task automatic test_reset_in_drain();
    bit ok;
    apply_reset();
    lock[0] = 1'b1;
    wait_ready(0);
    send_byte(0, 8'h33);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (grant !== 3'b000 || tx_start !== 1'b0 || rtb !== 3'b111 || terr !== 1'b0) begin
      bad++;
      $display("FAIL drain_reset: got grant=%b start=%b busy=%b terr=%b want 000/0/111/0",
               grant, tx_start, rtb, terr);
    end
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (tx_busy !== 1'b1) begin
        ok = 1'b1;
        break;
      end
      total++;
      if (grant !== 3'b000) begin
        bad++;
        $display("FAIL drain_hold: got grant=%b while tx_busy want 000", grant);
      end
      @(negedge clk);
    end
    total++;
    if (!ok || grant !== 3'b000) begin
      bad++;
      $display("FAIL drain_fall: got fell=%b grant=%b want 1/000", ok, grant);
    end
    @(negedge clk);
    total++;
    if (grant !== 3'b001) begin
      bad++;
      $display("FAIL drain_regrant: got grant=%b want 001", grant);
    end
    lock = '0;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    apply_reset();
    valid = 3'b111;
    @(negedge clk);
    valid = '0;
    total++;
    if (dcnt !== 8'd1) begin
      bad++;
      $display("FAIL multi_reject: got %0d want 1", dcnt);
    end
    valid[1] = 1'b1;
    repeat (253) @(negedge clk);
    total++;
    if (dcnt !== 8'hFE) begin
      bad++;
      $display("FAIL drop_254: got %h want fe", dcnt);
    end
    repeat (46) @(negedge clk);
    valid = '0;
    total++;
    if (dcnt !== 8'hFF) begin
      bad++;
      $display("FAIL drop_sat: got %h want ff", dcnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_in_drain();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
